seq_decode_stage: RTL and testbench
===================================

Name: seq_decode_stage

Overview:
Registered, handshaked successor to the combinational sequencer word decoder. It accepts one sequencer word per cycle with its program address and decodes command type, instruction type and instruction data. It resolves jumps to an absolute target address, with a taken/not-taken decision and a range-error flag. Results are buffered in a 2-entry skid buffer so the sequencer fetch and execute stages are decoupled at full throughput. It sits between word fetch (program memory) and the execute/bus-driver stage; a flush input discards in-flight words on redirect.

Parameters:
ADDR_W, 8, program address width; must satisfy ADDR_W >= JMP_W
JMP_W, get_jmp_width(), jump offset field width (package constant, not overridden)
WORD_W, get_word_width(), sequencer word width (package constant)
COND_JMP_INVERT, 0, 1 = INSTR_COMP_JMP is taken when cond_i==0

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous, active-high reset
flush_i  in  1  drop all buffered and incoming words this cycle
word_i  in  WORD_W  sequencer word (seq_word_t)
pc_i  in  ADDR_W  address of word_i
cond_i  in  1  comparison flag for INSTR_COMP_JMP, sampled with word_i
word_valid_i  in  1  word_i/pc_i/cond_i valid
word_ready_o  out  1  stage can accept (registered)
out_valid_o  out  1  decoded entry valid
out_ready_i  in  1  consumer accepts entry
cmd_type_o  out  cmd_t  decoded command type
instr_type_o  out  instr_t  decoded instruction type
instr_data_o  out  instr_data_t  decoded instruction data
pc_o  out  ADDR_W  address of decoded word
jmp_taken_o  out  1  entry is a taken jump
jmp_target_o  out  ADDR_W  absolute jump target (valid when jmp_taken_o)
jmp_err_o  out  1  target computation over/underflowed

Behaviour:
- Accept = word_valid_i & word_ready_o & ~flush_i; pop = out_valid_o & out_ready_i.
- Decode is combinational on word_i and is registered on accept, so latency is 1 cycle from accept to out_valid_o when the buffer is empty.
- Buffer FSM has states EMPTY, ONE, TWO. word_ready_o = (state != TWO), registered from the next state. out_valid_o = (state != EMPTY). Entry 0 is the head.
  EMPTY: accept -> ONE.
  ONE: accept & ~pop -> TWO; pop & ~accept -> EMPTY; accept & pop -> ONE, with the new entry becoming head.
  TWO: pop -> ONE, with entry 1 shifting to head. word_ready_o is 0, so no accept is possible.
- Output order is strict FIFO; no reordering and no drop except on flush.
- is_jump = (cmd_type == RUN_INSTR) & (instr_type ∈ {INSTR_UNCOND_JMP, INSTR_COMP_JMP}).
- jmp_taken = is_jump & (UNCOND | (cond_i ^ COND_JMP_INVERT)). cond_i is sampled at accept only.
- Target: offset = zero-extended jmp data field. Arithmetic is done in ADDR_W+1 bits: jmp_dir == JUMP_BACK gives pc - offset, otherwise pc + offset.
  - jmp_target_o takes the low ADDR_W bits (wraps modulo 2^ADDR_W).
  - jmp_err_o = carry/borrow bit & is_jump. The error is flagged even if the jump is not taken.
- For non-jump entries: jmp_taken_o = 0, jmp_err_o = 0, jmp_target_o = 0.
- flush_i: the next state is EMPTY and the incoming word is dropped; flush has priority over accept and pop. A pop in the flush cycle is still a legal handshake for the current head.
- Reset (rst_i=1 at an edge): state EMPTY; word_ready_o = 0 during reset and 1 from the first cycle after rst_i deasserts. All payload outputs are 0, out_valid_o = 0. Reset mid-operation discards all entries.
- Payload outputs hold stable while out_valid_o & ~out_ready_i. Payload is don't-care while out_valid_o = 0 but is driven from the head register (no X).

Decomposition:
- bus_sequencer_pkg additions: decoded_entry_t struct (cmd_t, instr_t, instr_data_t, pc, jmp_taken, jmp_target, jmp_err) parametrised via ADDR_W-sized localparam MAX_ADDR_W; function resolve_jump(pc, offset, back) returning {err, target}. Reuse the existing get_word_type / get_instruction_type / get_instruction_data.
- One sub-module: seq_skid_buf2 (generic 2-entry valid/ready buffer of decoded_entry_t) holding the FSM; the top level does decode + jump resolution only.

Test Plan:
- Reset: hold rst_i 3 cycles with word_valid_i=1 -> out_valid_o=0 and word_ready_o=0 throughout; word_ready_o=1 on the first cycle after release.
- Forward jump: INSTR_UNCOND_JMP, pc_i=0x10, offset 5, forward -> 1 cycle later out_valid_o=1, jmp_taken_o=1, jmp_target_o=0x15, jmp_err_o=0.
- Back jump underflow: INSTR_COMP_JMP, pc_i=0x02, offset 4, back, cond_i=1 (ADDR_W=8) -> jmp_target_o=0xFE, jmp_err_o=1, jmp_taken_o=1; same with cond_i=0 -> jmp_taken_o=0, jmp_err_o=1.
- Backpressure: stream 4 non-jump words with out_ready_i=0 -> word_ready_o drops after 2 accepts. Release out_ready_i -> all 4 emerge in order with pc 0,1,2,3, none lost or duplicated.
- Full throughput: word_valid_i=1 and out_ready_i=1 continuously for 16 words -> one output per cycle, word_ready_o never 0.
- Flush: 2 entries buffered, flush_i=1 with word_valid_i=1 -> next cycle out_valid_o=0 and the incoming word is never output.

Source files
------------

// File: rtl/seq_decode_stage_pkg.sv
// Shared sequencer word types, decode helpers and the decoded-entry record
// passed from the decode stage to the execute stage.
package seq_decode_stage_pkg;

   localparam int WORD_WIDTH   = 16;
   localparam int JMP_WIDTH    = 6;
   localparam int INSTR_DATA_W = 11;
   localparam int MAX_ADDR_W   = 16;
   localparam int JMP_DIR_BIT  = JMP_WIDTH;

   typedef logic [WORD_WIDTH-1:0]   seq_word_t;
   typedef logic [INSTR_DATA_W-1:0] instr_data_t;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'd0,
      RUN_INSTR = 2'd1,
      CMD_WAIT  = 2'd2,
      CMD_HALT  = 2'd3
   } cmd_t;

   typedef enum logic [2:0] {
      INSTR_NOP        = 3'd0,
      INSTR_WRITE      = 3'd1,
      INSTR_READ       = 3'd2,
      INSTR_UNCOND_JMP = 3'd3,
      INSTR_COMP_JMP   = 3'd4,
      INSTR_WAIT_EV    = 3'd5,
      INSTR_SET_FLAG   = 3'd6,
      INSTR_CLR_FLAG   = 3'd7
   } instr_t;

   typedef enum logic {
      JUMP_FWD  = 1'b0,
      JUMP_BACK = 1'b1
   } jmp_dir_t;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_t;

   // Addresses are carried at MAX_ADDR_W; the stage uses the low ADDR_W bits.
   typedef struct packed {
      cmd_t                  cmd_type;
      instr_t                instr_type;
      instr_data_t           instr_data;
      logic [MAX_ADDR_W-1:0] pc;
      logic                  jmp_taken;
      logic [MAX_ADDR_W-1:0] jmp_target;
      logic                  jmp_err;
   } decoded_entry_t;

   function automatic int get_word_width();
      return WORD_WIDTH;
   endfunction

   function automatic int get_jmp_width();
      return JMP_WIDTH;
   endfunction

   function automatic cmd_t get_word_type(input seq_word_t word);
      return cmd_t'(word[WORD_WIDTH-1 -: 2]);
   endfunction

   function automatic instr_t get_instruction_type(input seq_word_t word);
      return instr_t'(word[WORD_WIDTH-3 -: 3]);
   endfunction

   function automatic instr_data_t get_instruction_data(input seq_word_t word);
      return word[INSTR_DATA_W-1:0];
   endfunction

   // Bits above the caller's address width hold the carry/borrow.
   function automatic logic [MAX_ADDR_W:0] resolve_jump(
      input logic [MAX_ADDR_W-1:0] pc,
      input logic [MAX_ADDR_W-1:0] offset,
      input logic                  back
   );
      if (back)
         return {1'b0, pc} - {1'b0, offset};
      else
         return {1'b0, pc} + {1'b0, offset};
   endfunction

endpackage

// File: rtl/seq_skid_buf2.sv
// Two-entry valid/ready buffer for decoded entries; entry 0 is always the head
// and drives the output, so payload is stable while the consumer stalls.
module seq_skid_buf2
   import seq_decode_stage_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           flush_i,
   input  logic           in_valid_i,
   input  decoded_entry_t in_data_i,
   output logic           in_ready_o,
   output logic           out_valid_o,
   output decoded_entry_t out_data_o,
   input  logic           out_ready_i
);

   buf_state_t     state_reg;
   buf_state_t     state_next;
   decoded_entry_t entry0_reg;
   decoded_entry_t entry1_reg;
   logic           ready_reg;
   logic           accept;
   logic           pop;

   assign accept = in_valid_i & ready_reg & ~flush_i;
   assign pop    = (state_reg != BUF_EMPTY) & out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= BUF_EMPTY;
         ready_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         ready_reg <= (state_next != BUF_TWO);
      end
   end

   always_comb begin
      state_next = state_reg;
      if (flush_i) begin
         state_next = BUF_EMPTY;
      end else begin
         case (state_reg)
            BUF_EMPTY: if (accept) state_next = BUF_ONE;
            BUF_ONE: begin
               if (accept && !pop)
                  state_next = BUF_TWO;
               else if (pop && !accept)
                  state_next = BUF_EMPTY;
            end
            BUF_TWO:   if (pop) state_next = BUF_ONE;
            default:   state_next = BUF_EMPTY;
         endcase
      end
   end

   // Incoming data always lands in the head slot unless the head is still waiting.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         entry0_reg <= '0;
         entry1_reg <= '0;
      end else begin
         case (state_reg)
            BUF_EMPTY: if (accept) entry0_reg <= in_data_i;
            BUF_ONE: begin
               if (accept && pop)
                  entry0_reg <= in_data_i;
               else if (accept)
                  entry1_reg <= in_data_i;
            end
            BUF_TWO:   if (pop) entry0_reg <= entry1_reg;
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready_o  = ready_reg;
      out_valid_o = (state_reg != BUF_EMPTY);
      out_data_o  = entry0_reg;
   end

endmodule

// File: rtl/seq_decode_stage.sv
// Registered sequencer word decoder: decodes command/instruction fields and
// resolves jumps to absolute targets, buffered through a 2-entry skid buffer.
module seq_decode_stage
   import seq_decode_stage_pkg::*;
#(
   parameter int ADDR_W          = 8,
   parameter int JMP_W           = get_jmp_width(),
   parameter int WORD_W          = get_word_width(),
   parameter bit COND_JMP_INVERT = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              cond_i,
   input  logic              word_valid_i,
   output logic              word_ready_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output cmd_t              cmd_type_o,
   output instr_t            instr_type_o,
   output instr_data_t       instr_data_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              jmp_taken_o,
   output logic [ADDR_W-1:0] jmp_target_o,
   output logic              jmp_err_o
);

   // ADDR_W must lie in [JMP_W, MAX_ADDR_W] for the offset and carry bit to fit.
   cmd_t                  cmd_type;
   instr_t                instr_type;
   instr_data_t           instr_data;
   logic [JMP_W-1:0]      jmp_offset;
   logic                  jmp_back;
   logic                  is_jump;
   logic [MAX_ADDR_W:0]   jmp_sum;
   decoded_entry_t        in_entry;
   decoded_entry_t        out_entry;
   logic                  unused_bits;

   always_comb begin
      cmd_type   = get_word_type(word_i);
      instr_type = get_instruction_type(word_i);
      instr_data = get_instruction_data(word_i);
      jmp_offset = instr_data[JMP_W-1:0];
      jmp_back   = (instr_data[JMP_DIR_BIT] == JUMP_BACK);
      is_jump    = (cmd_type == RUN_INSTR) &&
                   ((instr_type == INSTR_UNCOND_JMP) || (instr_type == INSTR_COMP_JMP));
      jmp_sum    = resolve_jump(MAX_ADDR_W'(pc_i), MAX_ADDR_W'(jmp_offset), jmp_back);

      in_entry            = '0;
      in_entry.cmd_type   = cmd_type;
      in_entry.instr_type = instr_type;
      in_entry.instr_data = instr_data;
      in_entry.pc         = MAX_ADDR_W'(pc_i);
      // Range error is reported for any jump, taken or not.
      if (is_jump) begin
         in_entry.jmp_taken  = (instr_type == INSTR_UNCOND_JMP) | (cond_i ^ COND_JMP_INVERT);
         in_entry.jmp_target = MAX_ADDR_W'(jmp_sum[ADDR_W-1:0]);
         in_entry.jmp_err    = jmp_sum[ADDR_W];
      end
   end

   seq_skid_buf2 u_skid (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (word_valid_i),
      .in_data_i   (in_entry),
      .in_ready_o  (word_ready_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_entry),
      .out_ready_i (out_ready_i)
   );

   assign cmd_type_o   = out_entry.cmd_type;
   assign instr_type_o = out_entry.instr_type;
   assign instr_data_o = out_entry.instr_data;
   assign pc_o         = out_entry.pc[ADDR_W-1:0];
   assign jmp_taken_o  = out_entry.jmp_taken;
   assign jmp_target_o = out_entry.jmp_target[ADDR_W-1:0];
   assign jmp_err_o    = out_entry.jmp_err;

   assign unused_bits = ^{out_entry, jmp_sum};

endmodule

// File: tb/tb_seq_decode_stage.sv
// Directed bench for seq_decode_stage with a queue scoreboard of expected entries.
module tb_seq_decode_stage;
   import seq_decode_stage_pkg::*;

   localparam int ADDR_W = 8;

   typedef struct packed {
      logic [1:0]  cmd;
      logic [2:0]  instr;
      logic [10:0] data;
      logic [7:0]  pc;
      logic        taken;
      logic [7:0]  target;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, flush, cond, word_valid, out_ready;
   logic [15:0] word;
   logic [7:0]  pc;
   logic        word_ready, out_valid;
   cmd_t        cmd_type;
   instr_t      instr_type;
   instr_data_t instr_data;
   logic [7:0]  pc_out, jmp_target;
   logic        jmp_taken, jmp_err;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_out = 0;
   int   accepts;
   bit   last_acc;

   always #5 clk = ~clk;

   seq_decode_stage #(.ADDR_W(ADDR_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .word_i       (word),
      .pc_i         (pc),
      .cond_i       (cond),
      .word_valid_i (word_valid),
      .word_ready_o (word_ready),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .cmd_type_o   (cmd_type),
      .instr_type_o (instr_type),
      .instr_data_o (instr_data),
      .pc_o         (pc_out),
      .jmp_taken_o  (jmp_taken),
      .jmp_target_o (jmp_target),
      .jmp_err_o    (jmp_err)
   );

   function automatic logic [15:0] mk_word(input logic [1:0] c, input logic [2:0] t,
                                           input logic back, input logic [5:0] off);
      return {c, t, 4'b0000, back, off};
   endfunction

   // Reference: integer arithmetic on the raw word layout.
   function automatic exp_t model(input logic [15:0] w, input logic [7:0] p, input logic c);
      exp_t e;
      int   off;
      int   t;
      bit   jump;
      e.cmd   = w[15:14];
      e.instr = w[13:11];
      e.data  = w[10:0];
      e.pc    = p;
      jump    = (w[15:14] == 2'd1) && (w[13:11] == 3'd3 || w[13:11] == 3'd4);
      off     = int'(w[5:0]);
      t       = w[6] ? int'(p) - off : int'(p) + off;
      e.taken  = jump && (w[13:11] == 3'd3 || c);
      e.target = jump ? t[7:0] : 8'h00;
      e.err    = jump && (t < 0 || t > 255);
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes mid-cycle, score the pop, model the accept.
   task automatic cycle();
      exp_t got;
      @(negedge clk);
      last_acc = word_valid && word_ready && !flush && !rst;
      if (out_valid && out_ready && !rst) begin
         got = {cmd_type, instr_type, instr_data, pc_out, jmp_taken, jmp_target, jmp_err};
         check("output_expected", 64'(q.size() != 0), 64'd1);
         if (q.size() != 0) begin
            check("entry", 64'(got), 64'(q[0]));
            void'(q.pop_front());
         end
         n_out++;
         $display("out pc=%h cmd=%0d instr=%0d taken=%0b target=%h err=%0b",
                  pc_out, cmd_type, instr_type, jmp_taken, jmp_target, jmp_err);
      end
      if (flush) q.delete();
      if (last_acc) q.push_back(model(word, pc, cond));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; cond = 1'b0; word_valid = 1'b1; out_ready = 1'b0;
      word = mk_word(2'd1, 3'd3, 1'b0, 6'd1); pc = 8'h00;

      // Reset held 3 cycles with a valid word offered
      @(posedge clk); #1;
      repeat (3) begin
         check("rst_out_valid", 64'(out_valid), 64'd0);
         check("rst_word_ready", 64'(word_ready), 64'd0);
         check("rst_pc_o", 64'(pc_out), 64'd0);
         @(posedge clk); #1;
      end
      rst = 1'b0; word_valid = 1'b0;
      cycle();
      check("ready_after_rst", 64'(word_ready), 64'd1);
      check("valid_after_rst", 64'(out_valid), 64'd0);

      // Forward unconditional jump
      out_ready = 1'b1;
      word = mk_word(2'd1, 3'd3, 1'b0, 6'd5); pc = 8'h10; word_valid = 1'b1;
      cycle();
      word_valid = 1'b0;
      check("fwd_valid", 64'(out_valid), 64'd1);
      check("fwd_taken", 64'(jmp_taken), 64'd1);
      check("fwd_target", 64'(jmp_target), 64'h15);
      check("fwd_err", 64'(jmp_err), 64'd0);
      cycle();

      // Backward conditional jump underflowing, cond=1 then cond=0
      word = mk_word(2'd1, 3'd4, 1'b1, 6'd4); pc = 8'h02; cond = 1'b1; word_valid = 1'b1;
      cycle();
      cond = 1'b0;
      check("back1_taken", 64'(jmp_taken), 64'd1);
      check("back1_target", 64'(jmp_target), 64'hFE);
      check("back1_err", 64'(jmp_err), 64'd1);
      cycle();
      word_valid = 1'b0;
      check("back0_taken", 64'(jmp_taken), 64'd0);
      check("back0_err", 64'(jmp_err), 64'd1);
      cycle();

      // Backpressure: 4 non-jump words with consumer stalled
      out_ready = 1'b0; pc = 8'h00; accepts = 0; word_valid = 1'b1;
      word = mk_word(2'd1, 3'd1, 1'b1, 6'd9);
      for (int i = 0; i < 10 && accepts < 2; i++) begin
         cycle();
         if (last_acc) begin accepts++; pc++; end
      end
      check("bp_accepts", 64'(accepts), 64'd2);
      check("bp_ready_low", 64'(word_ready), 64'd0);
      cycle();
      check("bp_ready_held", 64'(word_ready), 64'd0);
      check("bp_pc_head_stable", 64'(pc_out), 64'd0);
      out_ready = 1'b1; n_out = 0;
      for (int i = 0; i < 20 && (accepts < 4 || q.size() != 0); i++) begin
         if (accepts >= 4) word_valid = 1'b0;
         cycle();
         if (last_acc) begin accepts++; pc++; end
      end
      word_valid = 1'b0;
      check("bp_outputs", 64'(n_out), 64'd4);
      check("bp_drained", 64'(q.size()), 64'd0);

      // Full throughput: 16 back-to-back words, mixed types
      n_out = 0; out_ready = 1'b1; word_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         logic [5:0] off;
         off  = 6'($urandom_range(0, 63));
         pc   = 8'(8'hF0 + i);
         cond = 1'($urandom_range(0, 1));
         case (i % 4)
            0: word = mk_word(2'd1, 3'd3, 1'b0, off);
            1: word = mk_word(2'd1, 3'd4, 1'b1, off);
            2: word = mk_word(2'd0, 3'd3, 1'b0, off);
            default: word = mk_word(2'd1, 3'd2, 1'b1, off);
         endcase
         check("tp_ready", 64'(word_ready), 64'd1);
         if (i > 0) check("tp_valid", 64'(out_valid), 64'd1);
         cycle();
      end
      word_valid = 1'b0;
      cycle();
      check("tp_outputs", 64'(n_out), 64'd16);
      check("tp_drained", 64'(q.size()), 64'd0);

      // Flush with two entries buffered and a word offered
      n_out = 0; out_ready = 1'b0; word_valid = 1'b1;
      word = mk_word(2'd1, 3'd1, 1'b0, 6'd1);
      pc = 8'h20; cycle();
      pc = 8'h21; cycle();
      check("fl_full_valid", 64'(out_valid), 64'd1);
      check("fl_full_ready", 64'(word_ready), 64'd0);
      flush = 1'b1; pc = 8'h22;
      cycle();
      flush = 1'b0; word_valid = 1'b0;
      check("fl_valid_cleared", 64'(out_valid), 64'd0);
      check("fl_ready_back", 64'(word_ready), 64'd1);

      // Flush from one entry while ready, offered word must be dropped
      word_valid = 1'b1; pc = 8'h30; cycle();
      flush = 1'b1; pc = 8'h31; cycle();
      flush = 1'b0; word_valid = 1'b0; out_ready = 1'b1;
      check("fl1_valid_cleared", 64'(out_valid), 64'd0);
      repeat (4) cycle();
      check("fl_no_output", 64'(n_out), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
